// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ single-byte requesters.
// Optional I2C_ARB_PRIORITY_EN: requester 0 wins whenever pending; the rest stay round-robin.
module i2c_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int BUSY_WAIT   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   done,
    output logic                 done_err,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 mst_start,
    output logic                 mst_stop,
    output logic                 mst_rw,
    output logic [6:0]           mst_addr,
    output logic [7:0]           mst_wdata,
    input  logic                 mst_busy
);
    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CMAX = (TIMEOUT_CYC > BUSY_WAIT) ? TIMEOUT_CYC : BUSY_WAIT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
    localparam logic [CW-1:0] BW_LAST  = CW'(BUSY_WAIT - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ACTIVE, ARB_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d, owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, req_ack_q, req_ack_d, done_q, done_d;
    logic               done_err_q, done_err_d;
    logic               mst_start_q, mst_start_d, mst_stop_q, mst_stop_d;
    logic               mst_rw_q, mst_rw_d;
    logic [6:0]         mst_addr_q, mst_addr_d;
    logic [7:0]         mst_wdata_q, mst_wdata_d;

    logic               win_vld;
    logic [PW-1:0]      win_idx, cand;
    int                 scan_idx;
    logic               sel_rw;
    logic [6:0]         sel_addr;
    logic [7:0]         sel_wdata;

    // Winner search starts at rr_ptr and wraps; the command mux follows the winner.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            cand     = PW'(scan_idx);
            if (!win_vld && req_valid[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
`ifdef I2C_ARB_PRIORITY_EN
        if (req_valid[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
        end
`else
`endif
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == PW'(k)) begin
                sel_rw    = req_rw[k];
                sel_addr  = req_addr[7*k +: 7];
                sel_wdata = req_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        grant_d     = grant_q;
        req_ack_d   = '0;
        done_d      = '0;
        done_err_d  = 1'b0;
        mst_start_d = 1'b0;
        mst_stop_d  = mst_stop_q;
        mst_rw_d    = mst_rw_q;
        mst_addr_d  = mst_addr_q;
        mst_wdata_d = mst_wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_vld) begin
                    owner_d            = win_idx;
                    grant_d            = '0;
                    grant_d[win_idx]   = 1'b1;
                    req_ack_d[win_idx] = 1'b1;
                    mst_rw_d           = sel_rw;
                    mst_addr_d         = sel_addr;
                    mst_wdata_d        = sel_wdata;
                    state_d            = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                mst_start_d = 1'b1;
                mst_stop_d  = 1'b1;
                cnt_d       = '0;
                state_d     = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mst_busy) begin
                    cnt_d   = '0;
                    state_d = ARB_ACTIVE;
                end else if (cnt_q == BW_LAST) begin
                    err_d   = 1'b1;
                    state_d = ARB_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_ACTIVE: begin
                // A NACKed transfer also ends with busy low, so it reads as success here.
                if (!mst_busy) begin
                    err_d   = 1'b0;
                    state_d = ARB_RELEASE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ARB_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_RELEASE: begin
                done_d[owner_q] = 1'b1;
                done_err_d      = err_q;
                mst_stop_d      = 1'b0;
                grant_d         = '0;
                rr_ptr_d        = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                state_d         = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            grant_q     <= '0;
            req_ack_q   <= '0;
            done_q      <= '0;
            done_err_q  <= 1'b0;
            mst_start_q <= 1'b0;
            mst_stop_q  <= 1'b0;
            mst_rw_q    <= 1'b0;
            mst_addr_q  <= '0;
            mst_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            grant_q     <= grant_d;
            req_ack_q   <= req_ack_d;
            done_q      <= done_d;
            done_err_q  <= done_err_d;
            mst_start_q <= mst_start_d;
            mst_stop_q  <= mst_stop_d;
            mst_rw_q    <= mst_rw_d;
            mst_addr_q  <= mst_addr_d;
            mst_wdata_q <= mst_wdata_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign grant     = grant_q;
    assign mst_start = mst_start_q;
    assign mst_stop  = mst_stop_q;
    assign mst_rw    = mst_rw_q;
    assign mst_addr  = mst_addr_q;
    assign mst_wdata = mst_wdata_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: randomized requesters and master, transaction-level model, scoreboard monitor.
module tb_i2c_req_arbiter;
    localparam int N  = 4;
    localparam int BW = 4;
    localparam int TO = 64;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_valid, req_rw, req_ack, done, grant;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_wdata;
    logic           done_err, mst_start, mst_stop, mst_rw, mst_busy;
    logic [6:0]     mst_addr;
    logic [7:0]     mst_wdata;

    i2c_req_arbiter #(.NUM_REQ(N), .BUSY_WAIT(BW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .done(done), .done_err(done_err), .grant(grant),
        .mst_start(mst_start), .mst_stop(mst_stop), .mst_rw(mst_rw),
        .mst_addr(mst_addr), .mst_wdata(mst_wdata), .mst_busy(mst_busy)
    );

    typedef struct {
        int         who;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         d;      // busy rises d cycles after the start cycle; 0 = never
        int         len;    // busy high for len cycles
        bit         err;
        int         lat;    // cycles from mst_start to done
        bit         chained;
    } txn_t;

    txn_t       exp_q[$];
    txn_t       mst_q[$];
    int         n_checks = 0, n_err = 0;
    int         cyc;
    int         n_done = 0, n_pushed = 0;
    int         m_rr, last_w;
    logic [N-1:0] pend;
    logic       p_rw[N];
    logic [6:0] p_addr[N];
    logic [7:0] p_wdata[N];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: no DUT response within cycle budget (got none, required one)", name);
        finish_sim();
    endtask

    // Reference arbitration: first pending requester at or after the pointer, wrapping.
    function automatic int pick();
`ifdef I2C_ARB_PRIORITY_EN
        if (pend[0]) return 0;
`else
`endif
        for (int k = 0; k < N; k++)
            if (pend[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    task automatic new_pay(input int j);
        p_rw[j]    = 1'($urandom_range(1, 0));
        p_addr[j]  = 7'($urandom_range(127, 0));
        p_wdata[j] = 8'($urandom_range(255, 0));
    endtask

    task automatic drive();
        req_valid = pend;
        for (int j = 0; j < N; j++) begin
            req_rw[j]           = p_rw[j];
            req_addr[7*j +: 7]  = p_addr[j];
            req_wdata[8*j +: 8] = p_wdata[j];
        end
    endtask

    task automatic predict(input int fd, input int flen, input bit chained);
        txn_t t;
        int   w, r, m;
        w         = pick();
        t.who     = w;
        t.rw      = p_rw[w];
        t.addr    = p_addr[w];
        t.wdata   = p_wdata[w];
        t.chained = chained;
        if (fd >= 0) begin
            t.d   = fd;
            t.len = flen;
        end else begin
            r = $urandom_range(9, 0);
            t.d = $urandom_range(BW - 1, 1);
            if (r == 0)      begin t.d = 0; t.len = 0; end
            else if (r == 1) t.len = TO + $urandom_range(4, 1);
            else if (r == 2) t.len = TO;
            else             t.len = $urandom_range(12, 1);
        end
        if (t.d == 0) begin
            t.err = 1'b1;
            t.lat = BW + 1;
        end else begin
            m     = (t.len < TO) ? t.len : TO;
            t.err = (t.len > TO);
            t.lat = t.d + 2 + m;
        end
        exp_q.push_back(t);
        mst_q.push_back(t);
        m_rr   = (w + 1) % N;
        last_w = w;
        n_pushed++;
    endtask

    task automatic wait_ack(input int w);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (req_ack[w]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail("ack_timeout");
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (n_done == n_pushed) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout_fail("done_timeout");
        @(negedge clk);
    endtask

    // pol 0: winner drops; 1: winner re-requests with a new payload; 2: random churn.
    task automatic run_batch(input logic [N-1:0] init, input int ntx, input int pol,
                             input int fd, input int flen, input bit keep);
        int w;
        for (int j = 0; j < N; j++)
            if (init[j] && !keep) new_pay(j);
        pend = init;
        drive();
        predict(fd, flen, 1'b0);
        for (int t = 0; t < ntx; t++) begin
            w = last_w;
            wait_ack(w);
            if (t == ntx - 1) begin
                pend = '0;
            end else if (pol == 0) begin
                pend[w] = 1'b0;
            end else if (pol == 1) begin
                new_pay(w);
            end else begin
                if ($urandom_range(1, 0) == 1) new_pay(w);
                else pend[w] = 1'b0;
                for (int j = 0; j < N; j++) begin
                    if (j != w) begin
                        if (pend[j]) begin
                            if ($urandom_range(99, 0) < 15) pend[j] = 1'b0;
                        end else if ($urandom_range(99, 0) < 25) begin
                            new_pay(j);
                            pend[j] = 1'b1;
                        end
                    end
                end
            end
            drive();
            if (pend == '0) break;
            predict(-1, -1, 1'b1);
        end
        drain();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_rr  = 0;
        @(negedge clk);
    endtask

    // Master model: busy follows the mode queued with each transaction, drops on release.
    initial begin
        int   on_c, off_c;
        bit   act;
        txn_t m;
        on_c = 0; off_c = 0; act = 1'b0;
        mst_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mst_start && mst_q.size() > 0) begin
                m     = mst_q.pop_front();
                act   = (m.d != 0);
                on_c  = cyc + m.d;
                off_c = cyc + m.d + m.len;
            end
            if (done != '0 || grant == '0) act = 1'b0;
            mst_busy = act && (cyc >= on_c) && (cyc < off_c);
        end
    end

    // Scoreboard monitor.
    initial begin
        txn_t cur;
        bit   cur_v;
        int   ack_c, st_c, done_c;
        cur_v = 1'b0; ack_c = 0; st_c = -1000; done_c = -100;
        forever begin
            @(negedge clk);
            if (reset) begin
                cur_v = 1'b0;
                exp_q.delete();
            end else begin
                if (done != '0) begin
                    if (!cur_v) begin
                        chk("unexpected_done", done, 0);
                    end else begin
                        chk("done_onehot", done, oh(cur.who));
                        chk("done_err", done_err, cur.err);
                        chk("done_latency", cyc - st_c, cur.lat);
                        chk("grant_at_done", grant, 0);
                        chk("mst_stop_at_done", mst_stop, 0);
                        chk("fields_held", {mst_rw, mst_addr, mst_wdata}, {cur.rw, cur.addr, cur.wdata});
                        cur_v  = 1'b0;
                        done_c = cyc;
                        n_done++;
                    end
                end
                if (req_ack != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", req_ack, 0);
                    end else begin
                        cur   = exp_q.pop_front();
                        cur_v = 1'b1;
                        ack_c = cyc;
                        st_c  = -1000;
                        chk("req_ack", req_ack, oh(cur.who));
                        chk("grant", grant, oh(cur.who));
                        chk("fields_at_ack", {mst_rw, mst_addr, mst_wdata}, {cur.rw, cur.addr, cur.wdata});
                        if (cur.chained) chk("idle_gap", ack_c - done_c, 1);
                    end
                end
                if (mst_start) begin
                    if (!cur_v) begin
                        chk("unexpected_start", mst_start, 0);
                    end else begin
                        st_c = cyc;
                        chk("start_after_ack", st_c - ack_c, 1);
                        chk("mst_stop_owned", mst_stop, 1);
                        chk("fields_at_start", {mst_rw, mst_addr, mst_wdata}, {cur.rw, cur.addr, cur.wdata});
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        timeout_fail("global_watchdog");
    end

    initial begin
        reset = 1'b1;
        pend = '0; m_rr = 0; last_w = 0;
        for (int j = 0; j < N; j++) begin
            p_rw[j] = 1'b0; p_addr[j] = '0; p_wdata[j] = '0;
        end
        drive();
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_done", done, 0);
        chk("rst_done_err", done_err, 0);
        chk("rst_mst_start", mst_start, 0);
        chk("rst_mst_stop", mst_stop, 0);
        chk("rst_fields", {mst_rw, mst_addr, mst_wdata}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single write from requester 1, busy at +2 for 20 cycles.
        p_rw[1] = 1'b0; p_addr[1] = 7'h50; p_wdata[1] = 8'hA5;
        run_batch(4'b0010, 1, 0, 2, 20, 1'b1);

        // Pointer now at 2: contention between 0 and 2.
        run_batch(4'b0101, 4, 1, -1, -1, 1'b0);

        // All four held continuously from pointer 0.
        pulse_reset();
        run_batch(4'b1111, 5, 1, -1, -1, 1'b0);

        // Busy never rises, then the next requester is still serviced.
        run_batch(4'b1001, 2, 0, 0, 0, 1'b0);

        // Busy stuck high.
        run_batch(4'b0100, 1, 0, 1, TO + 50, 1'b0);

        // Reset in the middle of an active transfer.
        new_pay(1);
        pend = 4'b0010;
        drive();
        predict(1, 1000, 1'b0);
        wait_ack(1);
        pend = '0;
        drive();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_grant", grant, 0);
        chk("midrst_mst_stop", mst_stop, 0);
        chk("midrst_done", done, 0);
        chk("midrst_mst_start", mst_start, 0);
        @(negedge clk);
        reset = 1'b0;
        n_pushed--;
        m_rr = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no_done_after_reset", done, 0);
        end
        new_pay(2);
        run_batch(4'b0100, 1, 0, -1, -1, 1'b1);

        // Randomized traffic.
        for (int b = 0; b < 30; b++)
            run_batch(N'($urandom_range(15, 1)), 8, 2, -1, -1, 1'b0);

        repeat (5) @(negedge clk);
        finish_sim();
    end
endmodule
